// File: rtl/bus_timer.sv
// Memory-mapped 32-bit down-counting timer on the CPU start/busy handshake.
// Define TIMER_PRESCALE_EN to add the PRESCALE register (offset 4) and tick prescaler.
//
// state   | meaning
// IDLE    | waiting for a hit on the register window
// ACCESS  | busy=1, write performed or read data latched into q
// DONE    | busy=0, q valid
// RELEASE | waiting for the CPU to drop start
module bus_timer #(
    parameter logic [26:0] BASE_ADDR        = 27'h0C02630,
    parameter logic [15:0] PRESCALE_DEFAULT = 16'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [26:0] address,
    input  logic [31:0] data,
    input  logic        we,
    input  logic        start,
    output logic        busy,
    output logic [31:0] q,
    output logic        tmr_int
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCESS  = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    if (BASE_ADDR[2:0] != 3'b000 || $bits(PRESCALE_DEFAULT) != 16) begin : g_bad_param
        $error("bus_timer: BASE_ADDR must be 8-word aligned");
    end

    logic [1:0]  state_q, state_d;
    logic [2:0]  offset_q, offset_d;
    logic        we_q, we_d;
    logic [31:0] data_q, data_d;
    logic [31:0] q_q, q_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] count_q, count_d;
    logic        status_q, status_d;
    logic        tmr_int_q, tmr_int_d;

    logic        hit, wr, tick, expire;
    logic        wr_ctrl, wr_reload, wr_count, wr_status;
    logic [31:0] rdata;

`ifdef TIMER_PRESCALE_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic        wr_prescale;
`endif

    assign hit = start & (address[26:3] == BASE_ADDR[26:3]);
    assign wr  = (state_q == ST_ACCESS) & we_q;

    assign wr_ctrl   = wr & (offset_q == 3'd0);
    assign wr_reload = wr & (offset_q == 3'd1);
    assign wr_count  = wr & (offset_q == 3'd2);
    assign wr_status = wr & (offset_q == 3'd3);

`ifdef TIMER_PRESCALE_EN
    assign wr_prescale = wr & (offset_q == 3'd4);
    assign tick        = ctrl_q[0] & (pcnt_q == prescale_q);
`else
    assign tick = ctrl_q[0];
`endif

    // A bus write to COUNT overrides the tick, so it also suppresses the expiry.
    assign expire = tick & (count_q == 32'd1) & ~wr_count;

    always_comb begin
        rdata = 32'd0;
        case (offset_q)
            3'd0:    rdata = {29'd0, ctrl_q};
            3'd1:    rdata = reload_q;
            3'd2:    rdata = count_q;
            3'd3:    rdata = {31'd0, status_q};
`ifdef TIMER_PRESCALE_EN
            3'd4:    rdata = {16'd0, prescale_q};
`endif
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        we_d     = we_q;
        data_d   = data_q;
        q_d      = q_q;
        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    offset_d = address[2:0];
                    we_d     = we;
                    data_d   = data;
                    state_d  = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!we_q) begin
                    q_d = rdata;
                end
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_RELEASE;
            default: begin
                if (!start) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        reload_d  = reload_q;
        count_d   = count_q;
        status_d  = status_q;
        tmr_int_d = expire & ctrl_q[2];

        if (tick && count_q > 32'd1) begin
            count_d = count_q - 32'd1;
        end
        if (expire) begin
            if (ctrl_q[1]) begin
                count_d = reload_q;
            end else begin
                count_d   = 32'd0;
                ctrl_d[0] = 1'b0;
            end
        end

        if (wr_ctrl) begin
            ctrl_d = data_q[2:0];
        end
        if (wr_reload) begin
            reload_d = data_q;
        end
        if (wr_count) begin
            count_d = data_q;
        end
        // Clear first so a coincident expiry still leaves EXPIRED set.
        if (wr_status && data_q[0]) begin
            status_d = 1'b0;
        end
        if (expire) begin
            status_d = 1'b1;
        end
    end

`ifdef TIMER_PRESCALE_EN
    always_comb begin
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q + 16'd1;
        if (wr_prescale) begin
            prescale_d = data_q[15:0];
        end
        if (!ctrl_q[0] || wr_prescale || pcnt_q == prescale_q) begin
            pcnt_d = 16'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescale_q <= PRESCALE_DEFAULT;
            pcnt_q     <= 16'd0;
        end else begin
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            offset_q  <= 3'd0;
            we_q      <= 1'b0;
            data_q    <= 32'd0;
            q_q       <= 32'd0;
            ctrl_q    <= 3'd0;
            reload_q  <= 32'd0;
            count_q   <= 32'd0;
            status_q  <= 1'b0;
            tmr_int_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            we_q      <= we_d;
            data_q    <= data_d;
            q_q       <= q_d;
            ctrl_q    <= ctrl_d;
            reload_q  <= reload_d;
            count_q   <= count_d;
            status_q  <= status_d;
            tmr_int_q <= tmr_int_d;
        end
    end

    assign busy    = (state_q == ST_ACCESS);
    assign q       = q_q;
    assign tmr_int = tmr_int_q;

endmodule

// File: tb/tb_bus_timer.sv
// Scoreboard bench for bus_timer: accesses push expected read data, a monitor
// compares q whenever busy falls; interrupt timing is checked from a cycle log.
module tb_bus_timer;

    localparam logic [26:0] BASE = 27'h0C02630;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] address;
    logic [31:0] data;
    logic        we;
    logic        start;
    logic        busy;
    logic [31:0] q;
    logic        tmr_int;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int a_cyc;

    logic [31:0] exp_q[$];
    bit          chk_q[$];
    string       nm_q[$];
    int          int_log[$];
    logic        busy_prev = 1'b0;

    bus_timer dut (
        .clk     (clk),
        .reset   (reset),
        .address (address),
        .data    (data),
        .we      (we),
        .start   (start),
        .busy    (busy),
        .q       (q),
        .tmr_int (tmr_int)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: q is valid in the cycle busy falls.
    always @(negedge clk) begin
        if (busy_prev && !busy && !reset) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_response: got q=%h expected no access", q);
            end else begin
                logic [31:0] e;
                bit          c;
                string       n;
                e = exp_q.pop_front();
                c = chk_q.pop_front();
                n = nm_q.pop_front();
                if (c) check(n, q, e);
            end
        end
        busy_prev <= busy;
    end

    always @(negedge clk) begin
        if (!reset && tmr_int) int_log.push_back(cyc);
    end

    task automatic bus_acc(input logic [2:0] off, input logic w, input logic [31:0] d,
                           input logic [31:0] exp, input string nm, input int hold);
        int waited;
        exp_q.push_back(exp);
        chk_q.push_back(!w);
        nm_q.push_back(nm);
        address = BASE + {24'd0, off};
        we      = w;
        data    = d;
        start   = 1'b1;
        waited  = 0;
        @(negedge clk);
        while (!busy && waited < 4) begin
            @(negedge clk);
            waited++;
        end
        check({nm, "_busy_rise"}, 32'(busy), 32'd1);
        acc_cyc = cyc;
        @(negedge clk);
        check({nm, "_busy_width"}, 32'(busy), 32'd0);
        repeat (hold) begin
            @(negedge clk);
            check({nm, "_no_second_access"}, 32'(busy), 32'd0);
        end
        start = 1'b0;
        we    = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [31:0] d);
        bus_acc(off, 1'b1, d, 32'd0, "write", 0);
    endtask

    task automatic rd_reg(input logic [2:0] off, input logic [31:0] exp, input string nm);
        bus_acc(off, 1'b0, 32'd0, exp, nm, 0);
    endtask

    // Auto-reload with RELOAD=4 started from COUNT=2: count in cycle c, for c >= a+3.
    function automatic logic [31:0] auto_cnt(input int c, input int a);
        return 32'(4 - ((c - a - 3) % 4));
    endfunction

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        address = '0;
        data    = '0;
        we      = 1'b0;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_q", q, 32'd0);
        check("reset_tmr_int", 32'(tmr_int), 32'd0);
        rd_reg(3'd0, 32'd0, "reset_ctrl");
        rd_reg(3'd2, 32'd0, "reset_count");
        rd_reg(3'd3, 32'd0, "reset_status");

        // Handshake, register readback, start held high after completion
        wr_reg(3'd1, 32'hDEADBEEF);
        bus_acc(3'd1, 1'b0, 32'd0, 32'hDEADBEEF, "rd_reload_hold", 5);
        wr_reg(3'd0, 32'hFFFF_FFF2);
        rd_reg(3'd0, 32'd2, "ctrl_upper_bits");
        wr_reg(3'd0, 32'd0);

`ifdef TIMER_PRESCALE_EN
        wr_reg(3'd4, 32'd2);
        rd_reg(3'd4, 32'd2, "prescale_rd");
`else
        wr_reg(3'd4, 32'd7);
        rd_reg(3'd4, 32'd0, "off4_reads_zero");
`endif
        wr_reg(3'd5, 32'd9);
        rd_reg(3'd5, 32'd0, "off5_reads_zero");

`ifdef TIMER_PRESCALE_EN
        // PRESCALE=2: ticks in A+3 and A+6, expiry at A+6, pulse in A+7
        int_log.delete();
        wr_reg(3'd2, 32'd2);
        wr_reg(3'd0, 32'd5);
        a_cyc = acc_cyc;
        repeat (8) @(negedge clk);
        check("pre_int_count", 32'(int_log.size()), 32'd1);
        if (int_log.size() > 0) check("pre_int_cycle", 32'(int_log[0]), 32'(a_cyc + 7));
        wr_reg(3'd4, 32'd0);
        wr_reg(3'd3, 32'd1);
`endif

        // One-shot: COUNT=3, CTRL=IE|EN written in cycle A; ticks A+1..A+3, pulse in A+4
        int_log.delete();
        wr_reg(3'd2, 32'd3);
        wr_reg(3'd0, 32'd5);
        a_cyc = acc_cyc;
        repeat (6) @(negedge clk);
        check("oneshot_int_count", 32'(int_log.size()), 32'd1);
        if (int_log.size() > 0) check("oneshot_int_cycle", 32'(int_log[0]), 32'(a_cyc + 4));
        rd_reg(3'd2, 32'd0, "oneshot_count");
        rd_reg(3'd0, 32'd4, "oneshot_en_cleared");
        rd_reg(3'd3, 32'd1, "oneshot_status");
        wr_reg(3'd3, 32'd1);
        rd_reg(3'd3, 32'd0, "status_cleared");

        // Auto-reload: RELOAD=4, COUNT=2; pulses in A+3, A+7, A+11
        int_log.delete();
        wr_reg(3'd1, 32'd4);
        wr_reg(3'd2, 32'd2);
        wr_reg(3'd0, 32'd7);
        a_cyc = acc_cyc;
        rd_reg(3'd2, auto_cnt(cyc + 1, a_cyc), "auto_count_a");
        @(negedge clk);
        rd_reg(3'd2, auto_cnt(cyc + 1, a_cyc), "auto_count_b");
        check("auto_int_count", 32'(int_log.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < int_log.size()) check("auto_int_cycle", 32'(int_log[i]), 32'(a_cyc + 3 + 4 * i));
        end
        wr_reg(3'd0, 32'd0);

        // EXPIRED clear in the same cycle as the expiry (COUNT=4 expires in A+4)
        wr_reg(3'd3, 32'd1);
        wr_reg(3'd2, 32'd4);
        wr_reg(3'd0, 32'd1);
        wr_reg(3'd3, 32'd1);
        rd_reg(3'd3, 32'd1, "clr_vs_expire_status");
        rd_reg(3'd0, 32'd0, "clr_vs_expire_ctrl");

        // COUNT write of 10 in the COUNT==1 tick cycle A+4: no interrupt,
        // counting resumes from 10, so a read in A+8 returns 7
        wr_reg(3'd3, 32'd1);
        int_log.delete();
        wr_reg(3'd2, 32'd4);
        wr_reg(3'd0, 32'd5);
        wr_reg(3'd2, 32'd10);
        rd_reg(3'd2, 32'd7, "count_wr_wins");
        check("count_wr_no_int", 32'(int_log.size()), 32'd0);
        wr_reg(3'd0, 32'd0);
        rd_reg(3'd3, 32'd0, "count_wr_no_status");

        // Non-hit access: start held at BASE+8 never raises busy
        address = BASE + 27'd8;
        we      = 1'b1;
        data    = 32'd7;
        start   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("nonhit_busy", 32'(busy), 32'd0);
        end
        start = 1'b0;
        we    = 1'b0;
        repeat (2) @(negedge clk);
        rd_reg(3'd0, 32'd0, "nonhit_no_write");

        // Reset during ACCESS of a CTRL write
        wr_reg(3'd2, 32'd5);
        wr_reg(3'd0, 32'd2);
        rd_reg(3'd1, 32'd4, "pre_reset_reload");
        address = BASE;
        we      = 1'b1;
        data    = 32'd7;
        start   = 1'b1;
        @(negedge clk);
        check("rst_access_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy_drop", 32'(busy), 32'd0);
        start = 1'b0;
        we    = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_q", q, 32'd0);
        check("rst_tmr_int", 32'(tmr_int), 32'd0);
        rd_reg(3'd0, 32'd0, "rst_ctrl");
        rd_reg(3'd1, 32'd0, "rst_reload");
        rd_reg(3'd2, 32'd0, "rst_count");
        rd_reg(3'd3, 32'd0, "rst_status");

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL pending_responses: got %0d outstanding expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 32-bit down-counting timer.
- Acts as a responder on the CPU memory handshake (address/data/we/start/busy/q), the same handshake the CPU drives toward the memory unit.
- The memory unit forwards accesses whose address hits BASE_ADDR.
- Drives a one-cycle interrupt pulse into a CPU interrupt input (int2 or int3).

Parameters:
- BASE_ADDR, 27'h0C02630, word address of register 0; bits [2:0] must be zero.
- PRESCALE_DEFAULT, 16'd0, reset value of PRESCALE register (used only with TIMER_PRESCALE_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  27  CPU word address
- data  in  32  CPU write data
- we  in  1  write enable, qualified by start
- start  in  1  access request, held high by the CPU until it sees busy fall
- busy  out  1  high while an access is in progress
- q  out  32  read data, valid in the cycle busy falls and held until the next access
- tmr_int  out  1  one-cycle expiry interrupt pulse

Behaviour:
- Reset: busy=0, q=0, tmr_int=0, CTRL=0, RELOAD=0, COUNT=0, EXPIRED=0, prescaler counter=0, FSM=IDLE.
- hit = start & (address[26:3]==BASE_ADDR[26:3]); offset = address[2:0].
- Register map (word offsets):
  - 0 CTRL: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable); other bits read 0.
  - 1 RELOAD: 32-bit reload value.
  - 2 COUNT: read returns live value; write loads it.
  - 3 STATUS: bit0 EXPIRED; writing 1 to bit0 clears it, writing 0 has no effect.
  - 4: PRESCALE (optional feature); otherwise reads 0, writes ignored.
  - 5-7: read 0, writes ignored.
- FSM states and transitions:
  - IDLE: on hit, capture offset/we/data; go to ACCESS.
  - ACCESS: busy=1; perform the write, or latch the read value into q; go to DONE.
  - DONE: busy=0, q valid; go to RELEASE.
  - RELEASE: wait for start=0, then go to IDLE. A start that stays high never causes a second access.
- Latency: start seen in cycle N -> busy=1 in N+1 -> busy=0 with q valid in N+2.
- start without hit is ignored: busy stays 0.
- Tick generation: tick = EN each cycle (without the prescaler).
- Counting, on each tick:
  - COUNT>1: COUNT <= COUNT-1.
  - COUNT==1: expiry event. COUNT <= RELOAD if AUTO, else COUNT <= 0 and EN <= 0. Set EXPIRED. tmr_int=1 for exactly the next cycle if IE.
  - COUNT==0 with EN=1: stall; no decrement, no event.
- Auto-reload with RELOAD=0: one expiry, then stall at 0.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the written value wins and no expiry fires that cycle.
  - Write to CTRL during expiry: the written CTRL wins, including EN.
  - EXPIRED clear in the same cycle as an expiry: set wins.
- Reading COUNT returns the value before that cycle's tick.
- Reset mid-access: FSM returns to IDLE, busy=0 the next cycle, and the access is discarded.

Optional Feature:
- Macro: TIMER_PRESCALE_EN.
- Defined:
  - Offset 4 is PRESCALE [15:0], reset value PRESCALE_DEFAULT, upper bits read 0.
  - A 16-bit prescaler counter runs while EN=1; tick fires when it equals PRESCALE, then it clears. Tick period is PRESCALE+1 cycles.
  - The prescaler counter clears whenever EN=0 or PRESCALE is written.
- Undefined:
  - No prescaler logic; tick = EN every cycle.
  - Offset 4 behaves like offsets 5-7.

Test Plan:
- Handshake: start=1 at BASE_ADDR+1, we=1, data=32'hDEADBEEF -> busy high 1 cycle, RELOAD=DEADBEEF. Read offset 1 -> q=32'hDEADBEEF when busy falls. start held 5 more cycles -> no second busy pulse.
- One-shot: COUNT=3, CTRL=3'b101 -> tmr_int pulses exactly 3 cycles after the EN write takes effect. COUNT=0, EN reads 0, STATUS=1. Write STATUS=1 -> reads 0.
- Auto-reload: RELOAD=4, COUNT=2, CTRL=3'b111 -> tmr_int pulses at cycles +2, +6, +10. COUNT cycles 4,3,2,1.
- Conflicts: STATUS clear coinciding with expiry -> STATUS stays 1. COUNT write of 10 coinciding with COUNT==1 tick -> COUNT=10 and no tmr_int.
- Non-hit and reset: start at BASE_ADDR+8 -> busy never rises. Reset asserted during ACCESS -> busy=0 next cycle and all registers return to 0.
- With TIMER_PRESCALE_EN: PRESCALE=2, COUNT=2, CTRL=3'b101 -> expiry 6 cycles after enable. Without the macro, offset 4 reads 0 after writing 7.
